// File: rtl/oculink_perst_seq.sv
// PERST# and cable-presence sequencer for one OCuLink PCIe root-port channel.
// Debounces CPRSNT#, holds PERST#, releases it, then supervises link-up with bounded retries.
module oculink_perst_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned HOLD_CYCLES     = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 10_000_000,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cprsnt,
  input  logic       link_up,
  output logic       perst_n,
  output logic       present,
  output logic       link_fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_TRAIN    = 3'd3,
    ST_UP       = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY - 1);

  logic             cp_meta_q, cp_sync_q;
  logic             prs;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             perst_q, perst_d;
  logic             present_q, present_d;
  logic             fail_q, fail_d;

  assign prs = ~cp_sync_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cp_meta_q <= 1'b1;
      cp_sync_q <= 1'b1;
    end else begin
      cp_meta_q <= cprsnt;
      cp_sync_q <= cp_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_ABSENT:   if (prs) state_d = ST_DEBOUNCE;
      ST_DEBOUNCE: if (cnt_q == DEB_LAST) begin
        state_d = ST_HOLD;
        retry_d = '0;
      end
      ST_HOLD:     if (cnt_q == HOLD_LAST) state_d = ST_TRAIN;
      ST_TRAIN: begin
        // link_up beats a coincident timeout
        if (link_up) begin
          state_d = ST_UP;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_LAST) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_HOLD;
            retry_d = retry_q + 4'd1;
          end
        end
      end
      ST_UP: if (!link_up) begin
        state_d = ST_HOLD;
        retry_d = '0;
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_ABSENT;
    endcase

    // Surprise removal overrides every other transition
    if (!prs && state_q != ST_ABSENT) begin
      state_d = ST_ABSENT;
      retry_d = '0;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == ST_DEBOUNCE || state_q == ST_HOLD || state_q == ST_TRAIN) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    perst_d   = (state_d == ST_TRAIN) || (state_d == ST_UP);
    present_d = (state_d == ST_HOLD) || (state_d == ST_TRAIN) ||
                (state_d == ST_UP)   || (state_d == ST_FAIL);
    fail_d    = (state_d == ST_FAIL);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q   <= ST_ABSENT;
      cnt_q     <= '0;
      retry_q   <= '0;
      perst_q   <= 1'b0;
      present_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      perst_q   <= perst_d;
      present_q <= present_d;
      fail_q    <= fail_d;
    end
  end

  assign perst_n   = perst_q;
  assign present   = present_q;
  assign link_fail = fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule
